// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants: opcodes, NOP word, immediate ranges and
// the opcode/funct3 -> instruction-format classifier.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IMM_I_MIN  = -32'sd2048;
  localparam int IMM_I_MAX  = 32'sd2047;
  localparam int IMM_SH_MIN = 32'sd0;
  localparam int IMM_SH_MAX = 32'sd31;
  localparam int IMM_B_MIN  = -32'sd4096;
  localparam int IMM_B_MAX  = 32'sd4094;
  localparam int IMM_J_MIN  = -32'sd1048576;
  localparam int IMM_J_MAX  = 32'sd1048574;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  function automatic fmt_e get_fmt(input logic [6:0] opcode, input logic [2:0] funct3);
    fmt_e fmt;
    case (opcode)
      OPC_OP:             fmt = FMT_R;
      OPC_OP_IMM:         fmt = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? FMT_SH : FMT_I;
      OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_STORE:          fmt = FMT_S;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      default:            fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational immediate scatter: places the immediate bits at their format's
// positions in the instruction word and reports whether the value is encodable.
module imm_packer
  import rv32i_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_imm,
  output fmt_e        o_fmt,
  output logic [31:0] o_imm_bits,
  output logic        o_legal
);

  logic signed [31:0] w_imm_s;
  fmt_e               w_fmt;

  assign w_imm_s = $signed(i_imm);
  assign w_fmt   = get_fmt(i_opcode, i_funct3);
  assign o_fmt   = w_fmt;

  // Scatter immediate bits and range-check per format
  always_comb begin
    o_imm_bits = 32'h0000_0000;
    o_legal    = 1'b0;
    case (w_fmt)
      FMT_R: begin
        o_legal = 1'b1;
      end
      FMT_I: begin
        o_imm_bits[31:20] = i_imm[11:0];
        o_legal = (w_imm_s >= IMM_I_MIN) && (w_imm_s <= IMM_I_MAX);
      end
      FMT_SH: begin
        o_imm_bits[24:20] = i_imm[4:0];
        o_legal = (w_imm_s >= IMM_SH_MIN) && (w_imm_s <= IMM_SH_MAX);
      end
      FMT_S: begin
        o_imm_bits[31:25] = i_imm[11:5];
        o_imm_bits[11:7]  = i_imm[4:0];
        o_legal = (w_imm_s >= IMM_I_MIN) && (w_imm_s <= IMM_I_MAX);
      end
      FMT_B: begin
        o_imm_bits[31]    = i_imm[12];
        o_imm_bits[30:25] = i_imm[10:5];
        o_imm_bits[11:8]  = i_imm[4:1];
        o_imm_bits[7]     = i_imm[11];
        o_legal = (w_imm_s >= IMM_B_MIN) && (w_imm_s <= IMM_B_MAX) && (i_imm[0] == 1'b0);
      end
      FMT_U: begin
        o_imm_bits[31:12] = i_imm[31:12];
        o_legal = (i_imm[11:0] == 12'h000);
      end
      FMT_J: begin
        o_imm_bits[31]    = i_imm[20];
        o_imm_bits[30:21] = i_imm[10:1];
        o_imm_bits[20]    = i_imm[11];
        o_imm_bits[19:12] = i_imm[19:12];
        o_legal = (w_imm_s >= IMM_J_MIN) && (w_imm_s <= IMM_J_MAX) && (i_imm[0] == 1'b0);
      end
      default: begin
        o_imm_bits = 32'h0000_0000;
        o_legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I encoder: assembles instruction words from decoded fields and
// emits them through one valid/ready register stage with sequential addresses.
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  fmt_e              w_fmt;
  logic [31:0]       w_imm_bits;
  logic              w_legal;
  logic [31:0]       w_word;
  logic [31:0]       w_instr;
  logic              w_accept;
  logic              w_out_hs;

  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_err;
  logic [7:0]        r_err_count;

  imm_packer u_imm_packer (
    .i_opcode   (in_opcode),
    .i_funct3   (in_funct3),
    .i_imm      (in_imm),
    .o_fmt      (w_fmt),
    .o_imm_bits (w_imm_bits),
    .o_legal    (w_legal)
  );

  // Register/funct fields per format; immediate bits are OR-ed in from the packer
  always_comb begin
    w_word = NOP_INSTR;
    case (w_fmt)
      FMT_R:        w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I:        w_word = {12'h000, in_rs1, in_funct3, in_rd, in_opcode} | w_imm_bits;
      FMT_SH:       w_word = {in_funct7, 5'h00, in_rs1, in_funct3, in_rd, in_opcode} | w_imm_bits;
      FMT_S, FMT_B: w_word = {7'h00, in_rs2, in_rs1, in_funct3, 5'h00, in_opcode} | w_imm_bits;
      FMT_U, FMT_J: w_word = {20'h00000, in_rd, in_opcode} | w_imm_bits;
      default:      w_word = NOP_INSTR;
    endcase
  end

  assign w_instr  = w_legal ? w_word : NOP_INSTR;
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  // Output stage, address counter and saturating error counter; clear beats handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0000_0000;
      r_out_addr  <= BASE_ADDR;
      r_out_err   <= 1'b0;
      r_err_count <= 8'h00;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0000_0000;
      r_out_addr  <= BASE_ADDR;
      r_out_err   <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      if (w_out_hs) begin
        r_out_addr <= r_out_addr + ADDR_STEP;
      end
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_instr;
        r_out_err   <= !w_legal;
        if (!w_legal && (r_err_count != 8'hFF)) begin
          r_err_count <= r_err_count + 8'h01;
        end
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed + randomized bench for rv32i_instr_encoder with a spec-level
// encode/decode model; a second instance checks ADDR_W=4 address wrap.
module tb_rv32i_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_count;

  logic        in_ready4, out_valid4, out_err4;
  logic [31:0] out_instr4;
  logic [3:0]  out_addr4;
  logic [7:0]  err_count4;

  int          n_assert = 0;
  int          n_fail   = 0;

  logic [31:0] exp_addr, exp_word;
  logic [3:0]  exp_addr4;
  logic        exp_err, held;
  int          exp_cnt;

  always #5 clk = ~clk;

  rv32i_instr_encoder u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  rv32i_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready4),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4),
    .out_addr(out_addr4), .out_err(out_err4), .err_count(err_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_shift(input logic [6:0] op, input logic [2:0] f3);
    return (op == 7'h13) && ((f3 == 3'd1) || (f3 == 3'd5));
  endfunction

  function automatic bit ref_legal(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (op)
      7'h33:               return 1'b1;
      7'h13, 7'h03, 7'h67: return is_shift(op, f3) ? (v >= 0 && v <= 31) : (v >= -2048 && v <= 2047);
      7'h23:               return v >= -2048 && v <= 2047;
      7'h63:               return v >= -4096 && v <= 4094 && imm[0] == 1'b0;
      7'h37, 7'h17:        return imm[11:0] == 12'h000;
      7'h6F:               return v >= -1048576 && v <= 1048574 && imm[0] == 1'b0;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    if (!ref_legal(op, f3, imm)) return 32'h0000_0013;
    case (op)
      7'h33:               return {f7, rs2, rs1, f3, rd, op};
      7'h13, 7'h03, 7'h67: return is_shift(op, f3) ? {f7, imm[4:0], rs1, f3, rd, op}
                                                    : {imm[11:0], rs1, f3, rd, op};
      7'h23:               return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      7'h63:               return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      7'h37, 7'h17:        return {imm[31:12], rd, op};
      7'h6F:               return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default:             return 32'h0000_0013;
    endcase
  endfunction

  // Immediate-generator model: recovers the signed immediate from a word
  function automatic logic [31:0] ref_decode(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67: return is_shift(w[6:0], w[14:12]) ? {27'd0, w[24:20]}
                                                             : {{20{w[31]}}, w[31:20]};
      7'h23:               return {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63:               return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'h37, 7'h17:        return {w[31:12], 12'h000};
      7'h6F:               return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:             return 32'h0000_0000;
    endcase
  endfunction

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    bit lg;
    if (held) begin
      exp_addr  = exp_addr + 32'd4;
      exp_addr4 = exp_addr4 + 4'd4;
    end
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1; out_ready = 1'b1;
    lg = ref_legal(op, f3, imm);
    exp_word = ref_encode(op, rd, rs1, rs2, f3, f7, imm);
    exp_err  = !lg;
    if (!lg && exp_cnt < 255) exp_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    held = 1'b1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_instr", out_instr, exp_word);
    chk("out_addr",  out_addr, exp_addr);
    chk("out_err",   32'(out_err), 32'(exp_err));
    chk("err_count", 32'(err_count), 32'(exp_cnt));
    chk("instr_w4",  out_instr4, exp_word);
    chk("addr_w4",   32'(out_addr4), 32'(exp_addr4));
    chk("err_w4",    32'(out_err4), 32'(exp_err));
    if (lg && op != 7'h33) chk("roundtrip_imm", ref_decode(out_instr), imm);
  endtask

  task automatic do_clear();
    clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_opcode = 7'h13; in_imm = 32'd7;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    held = 1'b0; exp_addr = 32'd0; exp_addr4 = 4'd12; exp_cnt = 0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_addr",  out_addr, 32'd0);
    chk("clr_addr4", 32'(out_addr4), 32'd12);
    chk("clr_cnt",   32'(err_count), 32'd0);
    chk("clr_valid4", 32'(out_valid4), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},  32'(out_valid), 32'd0);
    chk({tag, "_instr"},  out_instr, 32'd0);
    chk({tag, "_addr"},   out_addr, 32'd0);
    chk({tag, "_err"},    32'(out_err), 32'd0);
    chk({tag, "_cnt"},    32'(err_count), 32'd0);
    chk({tag, "_ready"},  32'(in_ready), 32'd1);
    chk({tag, "_addr4"},  32'(out_addr4), 32'd12);
    chk({tag, "_valid4"}, 32'(out_valid4), 32'd0);
    chk({tag, "_ready4"}, 32'(in_ready4), 32'd1);
    chk({tag, "_cnt4"},   32'(err_count4), 32'd0);
  endtask

  initial begin
    logic [6:0]  ops [9];
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] w1;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
    held = 1'b0; exp_addr = 32'd0; exp_addr4 = 4'd12; exp_cnt = 0;
    exp_word = 32'd0; exp_err = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("reset");
    rst = 1'b0;

    // ADDI x1,x0,-1
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    chk("addi_const", out_instr, 32'hFFF0_0093);

    // Illegal: ADDI 2048, BEQ 3, LUI 0x12345001, opcode 0x7F
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    chk("illegal_nop", out_instr, 32'h0000_0013);
    chk("illegal_cnt4", 32'(err_count), 32'd4);

    do_clear();

    // SW x2,8(x1); BEQ x0,x0,-4; LUI x5,0x12345000 back-to-back
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    chk("sw_const", out_instr, 32'h0020_A423);
    chk("sw_addr", out_addr, 32'd0);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    chk("beq_const", out_instr, 32'hFE00_0EE3);
    chk("beq_addr", out_addr, 32'd4);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    chk("lui_const", out_instr, 32'h1234_52B7);
    chk("lui_addr", out_addr, 32'd8);

    // Back-pressure: hold a word for 3 cycles with a new request waiting
    send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    w1 = exp_word;
    out_ready = 1'b0; in_valid = 1'b1;
    in_opcode = 7'h33; in_rd = 5'd4; in_rs1 = 5'd1; in_rs2 = 5'd2; in_funct3 = 3'd0; in_funct7 = 7'd0;
    #1;
    chk("stall_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_instr", out_instr, w1);
      chk("stall_addr",  out_addr, exp_addr);
      chk("stall_err",   32'(out_err), 32'd0);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    send(7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("release_addr", out_addr, 32'd16);

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    chk("sat_cnt", 32'(err_count), 32'd255);

    do_clear();

    // Randomized requests, mostly legal, against the model
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      case (op)
        7'h13, 7'h03, 7'h67, 7'h23:
          imm = is_shift(op, f3) ? 32'($urandom_range(0, 31)) : 32'(int'($urandom_range(0, 4095)) - 2048);
        7'h63:        imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        7'h37, 7'h17: imm = $urandom() & 32'hFFFF_F000;
        7'h6F:        imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
        default:      imm = $urandom();
      endcase
      if ($urandom_range(0, 5) == 0) imm = $urandom();
      if ($urandom_range(0, 7) == 0) op = 7'($urandom_range(0, 127));
      send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           f3, 7'($urandom_range(0, 127)), imm);
    end

    // Asynchronous reset while a word is held
    rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    held = 1'b0; exp_addr = 32'd0; exp_addr4 = 4'd12; exp_cnt = 0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    chk("post_rst_addr", out_addr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
